// File: rtl/systolic_mm_engine.sv
// Systolic matrix-multiply engine: streams K operand vector pairs through a
// ROWS x COLS array of accumulate-in-place processing elements, with internal
// input skewing, valid/ready stalling, saturate/wrap arithmetic, accumulator
// preload and registered row readout.
module systolic_mm_engine #(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int KW      = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [KW-1:0]             k_len,
   input  logic                      sat_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ROWS*BITS_AB-1:0]   A,
   input  logic [COLS*BITS_AB-1:0]   B,
   output logic                      busy,
   output logic                      done,
   input  logic                      WrEn,
   input  logic [$clog2(ROWS)-1:0]   Crow,
   input  logic [COLS*BITS_C-1:0]    Cin,
   input  logic                      rd_en,
   input  logic [$clog2(ROWS)-1:0]   rd_row,
   output logic                      rd_valid,
   output logic [COLS*BITS_C-1:0]    Cout
);

   localparam int RW = $clog2(ROWS);
   // Sum width holds accumulator plus full product without overflow.
   localparam int SW = ((BITS_C > 2*BITS_AB) ? BITS_C : 2*BITS_AB) + 1;
   localparam int CW = KW + $clog2(ROWS + COLS);
   // DRAIN runs ROWS+COLS-2 steps; the counter's final value is one less.
   localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS + COLS - 3);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [KW-1:0]     klen_q, klen_d;
   logic              sat_q, sat_d;
   logic              start_acc;
   logic              step;
   logic              pre_we;

   logic signed [BITS_AB-1:0] a_feed [ROWS];
   logic signed [BITS_AB-1:0] b_feed [COLS];
   logic signed [BITS_AB-1:0] a_in   [ROWS][COLS];
   logic signed [BITS_AB-1:0] b_in   [ROWS][COLS];
   logic signed [BITS_C-1:0]  acc_w  [ROWS][COLS];

   logic                      rd_valid_q;
   logic [COLS*BITS_C-1:0]    cout_q;

   // Control state register: FSM state, step counter and latched job settings.
   // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         klen_q  <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         klen_q  <= klen_d;
         sat_q   <= sat_d;
      end
   end

   // Next-state logic, step enable and status outputs.
   // NOTE: defaults first so every path assigns every output; no latch can be inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      klen_d    = klen_q;
      sat_d     = sat_q;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      start_acc = 1'b0;
      step      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               klen_d    = k_len;
               sat_d     = sat_en;
               cnt_d     = '0;
               state_d   = (k_len == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               step = 1'b1;
               if (cnt_q == CW'(klen_q) - CW'(1)) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Start wins over a same-cycle preload; preload is ignored while busy.
   assign pre_we = WrEn && !busy && !start_acc;

   genvar gi, gj;

   // Row-edge feed and A skew: row i is delayed by i steps; DRAIN feeds zeros.
   for (gi = 0; gi < ROWS; gi++) begin : g_skew_a
      assign a_feed[gi] = (state_q == S_LOAD) ? A[gi*BITS_AB +: BITS_AB] : '0;
      if (gi == 0) begin : g_direct
         assign a_in[gi][0] = a_feed[gi];
      end else begin : g_delay
         logic signed [BITS_AB-1:0] sr_q [gi];
         // Step-enabled shift chain; holds during stalls.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int d = 0; d < gi; d++) sr_q[d] <= '0;
            end else if (step) begin
               sr_q[0] <= a_feed[gi];
               for (int d = 1; d < gi; d++) sr_q[d] <= sr_q[d-1];
            end
         end
         assign a_in[gi][0] = sr_q[gi-1];
      end
   end

   // Column-edge feed and B skew: column j is delayed by j steps.
   for (gj = 0; gj < COLS; gj++) begin : g_skew_b
      assign b_feed[gj] = (state_q == S_LOAD) ? B[gj*BITS_AB +: BITS_AB] : '0;
      if (gj == 0) begin : g_direct
         assign b_in[0][gj] = b_feed[gj];
      end else begin : g_delay
         logic signed [BITS_AB-1:0] sr_q [gj];
         // Step-enabled shift chain; holds during stalls.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int d = 0; d < gj; d++) sr_q[d] <= '0;
            end else if (step) begin
               sr_q[0] <= b_feed[gj];
               for (int d = 1; d < gj; d++) sr_q[d] <= sr_q[d-1];
            end
         end
         assign b_in[0][gj] = sr_q[gj-1];
      end
   end

   // Processing elements.
   for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_pe
         logic signed [2*BITS_AB-1:0] prod;
         logic signed [SW-1:0]        sum;
         logic signed [BITS_C-1:0]    acc_q, acc_d;

         // Full-width signed MAC with optional clamp to the accumulator range.
         always_comb begin
            prod = (2*BITS_AB)'(a_in[gi][gj]) * (2*BITS_AB)'(b_in[gi][gj]);
            sum  = SW'(acc_q) + SW'(prod);
            if (sat_q && (sum[SW-1:BITS_C-1] != {(SW-BITS_C+1){sum[SW-1]}})) begin
               acc_d = sum[SW-1] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
            end else begin
               acc_d = sum[BITS_C-1:0];
            end
         end

         // Accumulator: clear on reset/start, accumulate on step, else preload.
         // NOTE: accumulators are reset explicitly because reset must leave every row reading zero.
         always_ff @(posedge clk) begin
            if (!rst_n)                            acc_q <= '0;
            else if (start_acc)                    acc_q <= '0;
            else if (step)                         acc_q <= acc_d;
            else if (pre_we && Crow == RW'(gi))    acc_q <= Cin[gj*BITS_C +: BITS_C];
         end
         assign acc_w[gi][gj] = acc_q;

         if (gj < COLS-1) begin : g_fwd_a
            logic signed [BITS_AB-1:0] a_q;
            // Forward A one column to the right per step.
            always_ff @(posedge clk) begin
               if (!rst_n)    a_q <= '0;
               else if (step) a_q <= a_in[gi][gj];
            end
            assign a_in[gi][gj+1] = a_q;
         end

         if (gi < ROWS-1) begin : g_fwd_b
            logic signed [BITS_AB-1:0] b_q;
            // Forward B one row down per step.
            always_ff @(posedge clk) begin
               if (!rst_n)    b_q <= '0;
               else if (step) b_q <= b_in[gi][gj];
            end
            assign b_in[gi+1][gj] = b_q;
         end
      end
   end

   // Registered row readout; refused while busy, Cout then holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         cout_q     <= '0;
      end else if (rd_en && !busy) begin
         rd_valid_q <= 1'b1;
         for (int j = 0; j < COLS; j++) cout_q[j*BITS_C +: BITS_C] <= acc_w[rd_row][j];
      end else begin
         rd_valid_q <= 1'b0;
      end
   end

   assign rd_valid = rd_valid_q;
   assign Cout     = cout_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed self-checking bench for systolic_mm_engine on a 4x4 array.
module tb_systolic_mm_engine;

   localparam int BAB = 8;
   localparam int BC  = 16;
   localparam int R   = 4;
   localparam int C   = 4;
   localparam int KW  = 8;

   logic              clk = 1'b0;
   logic              rst_n, start, sat_en, in_valid, in_ready;
   logic [KW-1:0]     k_len;
   logic [R*BAB-1:0]  A;
   logic [C*BAB-1:0]  B;
   logic              busy, done, WrEn, rd_en, rd_valid;
   logic [1:0]        Crow, rd_row;
   logic [C*BC-1:0]   Cin, Cout;

   int tests = 0;
   int fails = 0;
   int va [8][R];
   int vb [8][C];
   logic inj_rdv;

   always #5 clk = ~clk;

   systolic_mm_engine #(.BITS_AB(BAB), .BITS_C(BC), .ROWS(R), .COLS(C), .KW(KW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .sat_en(sat_en),
      .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .busy(busy), .done(done),
      .WrEn(WrEn), .Crow(Crow), .Cin(Cin), .rd_en(rd_en), .rd_row(rd_row),
      .rd_valid(rd_valid), .Cout(Cout)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int t);
      for (int i = 0; i < R; i++) A[i*BAB +: BAB] = BAB'(va[t][i]);
      for (int j = 0; j < C; j++) B[j*BAB +: BAB] = BAB'(vb[t][j]);
   endtask

   task automatic set_junk();
      A = {R{8'h5a}};
      B = {C{8'ha5}};
   endtask

   function automatic logic [C*BC-1:0] row_fill(input int v);
      logic [C*BC-1:0] r;
      for (int j = 0; j < C; j++) r[j*BC +: BC] = BC'(v);
      return r;
   endfunction

   function automatic logic [C*BC-1:0] row_b(input int i);
      logic [C*BC-1:0] r;
      for (int j = 0; j < C; j++) r[j*BC +: BC] = BC'(vb[i][j]);
      return r;
   endfunction

   // A = identity, B rows {1..4},{5..8},{9..12},{13..16}.
   task automatic load_identity();
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < R; i++) va[t][i] = (i == t) ? 1 : 0;
         for (int j = 0; j < C; j++) vb[t][j] = 4*t + j + 1;
      end
   endtask

   // Runs one job from IDLE; cycle 0 carries start. Stall mode drives in_valid
   // only on even cycles. Inject mode issues start+WrEn at cycle 2 (LOAD) and
   // rd_en at cycle k+1 (first DRAIN cycle), recording rd_valid one cycle later.
   task automatic run_job(input int k, input logic sat, input logic stall, input logic inject,
                          output int done_cyc, output int busy_first, output int busy_last,
                          output int busy_n, output int ready_n);
      int   t = 0;
      logic fin = 1'b0;
      done_cyc = -1; busy_first = -1; busy_last = -1; busy_n = 0; ready_n = 0;
      inj_rdv = 1'b0;
      start = 1'b1; k_len = KW'(k); sat_en = sat; in_valid = 1'b0; set_junk();
      for (int c = 1; c <= 200 && !fin; c++) begin
         tick();
         if (busy) begin
            if (busy_first < 0) busy_first = c;
            busy_last = c;
            busy_n++;
         end
         if (in_ready) ready_n++;
         if (done) begin
            done_cyc = c;
            fin = 1'b1;
         end
         if (inject && c == k + 2) inj_rdv = rd_valid;
         start = 1'b0; WrEn = 1'b0; rd_en = 1'b0;
         if (t < k && (!stall || (c % 2 == 0))) begin
            in_valid = 1'b1; set_vec(t); t++;
         end else begin
            in_valid = 1'b0; set_junk();
         end
         if (inject && c == 2) begin
            start = 1'b1; k_len = 8'd1; sat_en = ~sat;
            WrEn = 1'b1; Crow = 2'd0; Cin = row_fill(99);
         end
         if (inject && c == k + 1) begin
            rd_en = 1'b1; rd_row = 2'd0;
         end
      end
      start = 1'b0; WrEn = 1'b0; rd_en = 1'b0; in_valid = 1'b0;
      if (!fin) begin
         tests++; fails++;
         $display("FAIL job_timeout: done not seen within 200 cycles");
      end
   endtask

   task automatic read_row(input int r, output logic [C*BC-1:0] row, output logic vld);
      rd_en = 1'b1; rd_row = 2'(r);
      tick();
      rd_en = 1'b0;
      vld = rd_valid;
      row = Cout;
   endtask

   task automatic test_reset();
      logic [C*BC-1:0] row;
      logic vld;
      rst_n = 1'b0;
      tick(); tick();
      tests++;
      if ({busy, done, in_ready, rd_valid} !== 4'b0000 || Cout !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got busy/done/rdy/rdv=%b Cout=%h expected 0000 and 0",
                  {busy, done, in_ready, rd_valid}, Cout);
      end
      rst_n = 1'b1;
      tick();
      for (int r = 0; r < R; r++) begin
         read_row(r, row, vld);
         tests++;
         if (vld !== 1'b1 || row !== '0) begin
            fails++;
            $display("FAIL reset_row%0d: got vld=%b %h expected vld=1 0", r, vld, row);
         end
      end
   endtask

   task automatic test_identity();
      int dc, bf, bl, bn, rn;
      logic [C*BC-1:0] row;
      logic vld;
      load_identity();
      run_job(4, 1'b1, 1'b0, 1'b0, dc, bf, bl, bn, rn);
      tests++;
      if (dc !== 11) begin fails++; $display("FAIL identity_done_cycle: got %0d expected 11", dc); end
      tests++;
      if (bf !== 1 || bl !== 10 || bn !== 10) begin
         fails++; $display("FAIL identity_busy: got %0d..%0d n=%0d expected 1..10 n=10", bf, bl, bn);
      end
      tests++;
      if (rn !== 4) begin fails++; $display("FAIL identity_in_ready: got %0d cycles expected 4", rn); end
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL identity_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
      end
      for (int r = 0; r < R; r++) begin
         read_row(r, row, vld);
         tests++;
         if (vld !== 1'b1 || row !== row_b(r)) begin
            fails++; $display("FAIL identity_row%0d: got vld=%b %h expected vld=1 %h", r, vld, row, row_b(r));
         end
      end
   endtask

   task automatic test_stall();
      int dc, bf, bl, bn, rn;
      logic [C*BC-1:0] row;
      logic vld;
      load_identity();
      run_job(4, 1'b1, 1'b1, 1'b0, dc, bf, bl, bn, rn);
      tests++;
      if (dc !== 15) begin fails++; $display("FAIL stall_done_cycle: got %0d expected 15", dc); end
      tests++;
      if (bf !== 1 || bl !== 14 || bn !== 14 || rn !== 8) begin
         fails++;
         $display("FAIL stall_busy_ready: got busy %0d..%0d n=%0d rdy=%0d expected 1..14 n=14 rdy=8",
                  bf, bl, bn, rn);
      end
      tick();
      for (int r = 0; r < R; r++) begin
         read_row(r, row, vld);
         tests++;
         if (vld !== 1'b1 || row !== row_b(r)) begin
            fails++; $display("FAIL stall_row%0d: got %h expected %h", r, row, row_b(r));
         end
      end
   endtask

   task automatic test_saturation();
      int   av  [4] = '{127, 127, -128, -128};
      logic sv  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int   ev  [4] = '{32767, -1020, -32768, 512};
      int dc, bf, bl, bn, rn;
      logic [C*BC-1:0] row;
      logic vld;
      for (int n = 0; n < 4; n++) begin
         for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < R; i++) va[t][i] = av[n];
            for (int j = 0; j < C; j++) vb[t][j] = 127;
         end
         run_job(4, sv[n], 1'b0, 1'b0, dc, bf, bl, bn, rn);
         tests++;
         if (dc !== 11 || bn !== 10 || rn !== 4) begin
            fails++; $display("FAIL sat%0d_timing: got done=%0d busy_n=%0d rdy=%0d expected 11 10 4", n, dc, bn, rn);
         end
         tick();
         for (int r = 0; r < R; r++) begin
            read_row(r, row, vld);
            tests++;
            if (vld !== 1'b1 || row !== row_fill(ev[n])) begin
               fails++; $display("FAIL sat%0d_row%0d: got %h expected %h", n, r, row, row_fill(ev[n]));
            end
         end
      end
   endtask

   task automatic test_preload_clear();
      logic [C*BC-1:0] row;
      logic vld;
      WrEn = 1'b1; Crow = 2'd2; Cin = row_fill(7);
      tick();
      WrEn = 1'b0;
      read_row(2, row, vld);
      tests++;
      if (vld !== 1'b1 || row !== row_fill(7)) begin
         fails++; $display("FAIL preload_row2: got %h expected %h", row, row_fill(7));
      end
      rd_en = 1'b1; rd_row = 2'd2; WrEn = 1'b1; Crow = 2'd2; Cin = row_fill(9);
      tick();
      rd_en = 1'b0; WrEn = 1'b0;
      tests++;
      if (rd_valid !== 1'b1 || Cout !== row_fill(7)) begin
         fails++; $display("FAIL preload_read_old: got %h expected %h", Cout, row_fill(7));
      end
      read_row(2, row, vld);
      tests++;
      if (row !== row_fill(9)) begin
         fails++; $display("FAIL preload_row2_new: got %h expected %h", row, row_fill(9));
      end
      start = 1'b1; k_len = 8'd0; sat_en = 1'b0; WrEn = 1'b1; Crow = 2'd1; Cin = row_fill(5);
      tick();
      start = 1'b0; WrEn = 1'b0;
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL k0_done: got done=%b busy=%b expected 1 0", done, busy);
      end
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL k0_after: got done=%b busy=%b expected 0 0", done, busy);
      end
      for (int r = 0; r < R; r++) begin
         read_row(r, row, vld);
         tests++;
         if (vld !== 1'b1 || row !== '0) begin
            fails++; $display("FAIL k0_row%0d: got %h expected 0", r, row);
         end
      end
   endtask

   task automatic test_ignored();
      int dc, bf, bl, bn, rn;
      logic [C*BC-1:0] row;
      logic vld;
      load_identity();
      run_job(4, 1'b1, 1'b0, 1'b1, dc, bf, bl, bn, rn);
      tests++;
      if (dc !== 11 || bn !== 10) begin
         fails++; $display("FAIL ignored_timing: got done=%0d busy_n=%0d expected 11 10", dc, bn);
      end
      tests++;
      if (inj_rdv !== 1'b0) begin
         fails++; $display("FAIL ignored_rd_in_drain: got rd_valid=%b expected 0", inj_rdv);
      end
      tick();
      for (int r = 0; r < R; r++) begin
         read_row(r, row, vld);
         tests++;
         if (vld !== 1'b1 || row !== row_b(r)) begin
            fails++; $display("FAIL ignored_row%0d: got %h expected %h", r, row, row_b(r));
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int dc, bf, bl, bn, rn;
      logic [C*BC-1:0] row;
      logic vld;
      load_identity();
      start = 1'b1; k_len = 8'd4; sat_en = 1'b1; in_valid = 1'b0; set_junk();
      for (int c = 1; c <= 7; c++) begin
         tick();
         start = 1'b0;
         if (c <= 4) begin in_valid = 1'b1; set_vec(c - 1); end
         else begin in_valid = 1'b0; set_junk(); end
      end
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
      rst_n = 1'b0; rd_en = 1'b1; rd_row = 2'd0;
      tick();
      tests++;
      if ({busy, done, in_ready, rd_valid} !== 4'b0000) begin
         fails++; $display("FAIL rst_mid_outputs: got %b expected 0000", {busy, done, in_ready, rd_valid});
      end
      rst_n = 1'b1; rd_en = 1'b0;
      tick();
      for (int r = 0; r < R; r++) begin
         read_row(r, row, vld);
         tests++;
         if (vld !== 1'b1 || row !== '0) begin
            fails++; $display("FAIL rst_mid_row%0d: got %h expected 0", r, row);
         end
      end
      run_job(4, 1'b1, 1'b0, 1'b0, dc, bf, bl, bn, rn);
      tests++;
      if (dc !== 11 || bf !== 1 || rn !== 4) begin
         fails++; $display("FAIL rst_rerun_timing: got done=%0d busy_first=%0d rdy=%0d expected 11 1 4", dc, bf, rn);
      end
      tests++;
      if (bl !== 10 || bn !== 10) begin
         fails++; $display("FAIL rst_rerun_busy: got last=%0d n=%0d expected 10 10", bl, bn);
      end
      tick();
      for (int r = 0; r < R; r++) begin
         read_row(r, row, vld);
         tests++;
         if (vld !== 1'b1 || row !== row_b(r)) begin
            fails++; $display("FAIL rst_rerun_row%0d: got %h expected %h", r, row, row_b(r));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; k_len = '0; sat_en = 1'b0; in_valid = 1'b0;
      A = '0; B = '0; WrEn = 1'b0; Crow = '0; Cin = '0; rd_en = 1'b0; rd_row = '0;
      test_reset();
      test_identity();
      test_stall();
      test_saturation();
      test_preload_clear();
      test_ignored();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
